// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with fetch buffer and redirect handling
//
// Purpose: issues single-outstanding instruction memory requests, buffers the
// returned words with their PC in a small FIFO and presents the FIFO head to ID
// under a valid/stall handshake. Redirects flush the buffer and restart fetch.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/imem_addr       request to instruction memory (held until ack)
//   imem_ack/imem_data       memory response
//   id_stall                 ID cannot accept the presented instruction
//   redirect/redirect_pc     one-cycle flush-and-refetch pulse with target
//   id_valid/pc/instruction  presented instruction (NOP and fetch PC when empty)
//   fetch_misaligned         sticky misaligned-redirect trap flag
//
// Optional feature: define TITAN_MISALIGN_TRAP_EN to trap misaligned redirect
// targets; otherwise the two low target bits are forced to zero and
// fetch_misaligned stays 0.

module if_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        fetch_misaligned
);

  localparam int unsigned   PW      = $clog2(BUF_DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic          misalign_q, misalign_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_popped;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic          push, pop, flush;
  logic [31:0]   target_pc;
  logic          target_mis;

`ifdef TITAN_MISALIGN_TRAP_EN
  assign target_pc  = redirect_pc;
  assign target_mis = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc  = {redirect_pc[31:2], 2'b00};
  assign target_mis = 1'b0;
`endif

  // Presentation straight from the FIFO head.
  assign id_valid         = (count_q != '0);
  assign pc               = id_valid ? buf_pc[rd_ptr_q] : fetch_pc_q;
  assign instruction      = id_valid ? buf_instr[rd_ptr_q] : NOP;
  assign fetch_misaligned = misalign_q;

  // DROP must keep presenting the address of the abandoned request until its ack.
  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

  assign pop          = id_valid && !id_stall;
  assign count_popped = count_q - CW'(pop);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    misalign_d  = misalign_q;
    push        = 1'b0;
    flush       = 1'b0;

    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = target_pc;
      misalign_d = target_mis;
      unique case (state_q)
        IDLE: state_d = target_mis ? IDLE : REQ;
        REQ: begin
          if (imem_ack) begin
            state_d = IDLE;
          end else begin
            state_d     = DROP;
            drop_addr_d = fetch_pc_q;
          end
        end
        DROP: begin
          if (imem_ack) state_d = target_mis ? IDLE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          // No request is outstanding here, so free space alone decides.
          if (!misalign_q && (count_popped < DEPTH_C)) state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            // The next request will own a slot, so it needs room beyond this push.
            state_d    = ((count_popped + CW'(1)) < DEPTH_C) ? REQ : IDLE;
          end
        end
        DROP: begin
          // The buffer was flushed on entry and nothing is pushed here.
          if (imem_ack) state_d = misalign_q ? IDLE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_popped + CW'(push);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_ADDR;
      drop_addr_q <= RESET_ADDR;
      misalign_q  <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      misalign_q  <= misalign_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Buffer storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr_q]    <= fetch_pc_q;
      buf_instr[wr_ptr_q] <= imem_data;
    end
  end

endmodule
